// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - shared constants and FSM encoding for the MMIO UART transmitter
package mmio_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef MMIO_UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [31:0] UART_ADDR_DEFAULT = 32'hFFFF_FF00;
  localparam logic [31:0] CTRL_OFFSET       = 32'd4;
  localparam int          CTRL_OVR_CLR_BIT  = 0;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mmio_uart_fifo.sv
// rtl/mmio_uart_fifo.sv - byte FIFO with occupancy count; head entry is visible on dout
module mmio_uart_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  logic [7:0]                      din,
  output logic [7:0]                      dout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            full,
  output logic                            empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wr_en;
  logic          rd_en;

  // A push into a full FIFO is accepted only when the head leaves on the same edge
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - store-driven UART transmitter, 8N1 or 8E1 with MMIO_UART_TX_PARITY_EN
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] UART_ADDR    = UART_ADDR_DEFAULT,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            memwrite,
  input  logic [31:0]                     dataadr,
  input  logic [31:0]                     writedata,
  output logic                            txd,
  output logic                            tx_busy,
  output logic                            fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overrun
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic          pop;
  logic          bit_done;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic          data_sel, ctrl_sel, drop, ovr_clr;
  logic          unused_wd;

  assign data_sel  = memwrite && (dataadr == UART_ADDR);
  assign ctrl_sel  = memwrite && (dataadr == UART_ADDR + CTRL_OFFSET);
  assign drop      = data_sel && fifo_full && !pop;
  assign ovr_clr   = ctrl_sel && writedata[CTRL_OVR_CLR_BIT];
  assign unused_wd = ^writedata[31:8];

  mmio_uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_sel),
    .pop   (pop),
    .din   (writedata[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_done = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign tx_busy  = (state_q != ST_IDLE) || !fifo_empty;
  assign txd      = txd_q;

  // txd_d is the line level for the state being entered, so txd stays a pure flop output
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
          state_d = ST_START;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          txd_d   = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_d = ST_PARITY;
            txd_d   = even_parity(shreg_q);
`else
            state_d = ST_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shreg_q[bit_q + 3'd1];
          end
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
          baud_d  = '0;
          txd_d   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_dout;
            state_d = ST_START;
            txd_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  // A drop on the same edge as a clear leaves the flag set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the processor's data-memory write bus, alongside `dmem`. It consumes the same `memwrite`/`dataadr`/`writedata` signals the `mips` core drives, so programs running on the single-cycle core can emit serial characters. Each store to the data address buffers one byte in a small FIFO. A framing state machine serializes the FIFO contents onto `txd`.

## Interface
Parameters:
- `UART_ADDR`, 32'hFFFF_FF00: word address of the TX data register. `UART_ADDR+4` is the control register.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Must be ≥2.
- `FIFO_DEPTH`, 4: number of byte entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `memwrite`  in  1: store strobe from the core.
- `dataadr`  in  32: store address.
- `writedata`  in  32: store data. Only bits [7:0] are used for the data register.
- `txd`  out  1: serial output. Idle level is high.
- `tx_busy`  out  1: high while the FSM is outside IDLE or the FIFO is non-empty.
- `fifo_full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1): current number of entries.
- `overrun`  out  1: sticky flag. Set when a store is dropped because the FIFO is full.

## Operation
- Push: `memwrite=1` and `dataadr==UART_ADDR` at a rising edge writes `writedata[7:0]` into the FIFO.
  - If `fifo_full` and no pop occurs on that edge, the byte is dropped and `overrun` is set.
- Control register: `memwrite=1` and `dataadr==UART_ADDR+4` with `writedata[0]=1` clears `overrun`.
  - If a drop occurs on the same edge as a clear, the set wins.
- Stores to any other address are ignored.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE → START: on an edge where the FIFO is non-empty. That edge pops the head entry into the shift register.
  - START: drives `txd=0` for `CLKS_PER_BIT` cycles, then goes to DATA.
  - DATA: sends 8 bits, LSB first, each for `CLKS_PER_BIT` cycles, using a 3-bit bit index.
  - After DATA, the FSM goes to PARITY if the macro is defined, otherwise to STOP.
  - STOP: drives `txd=1` for `CLKS_PER_BIT` cycles.
  - At the end of STOP: if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Baud counter counts 0 to `CLKS_PER_BIT-1`. It reloads to 0 on every state or bit change.
- Simultaneous push and pop on one edge: both take effect and `fifo_count` is unchanged.
  - This also applies when full: the push is accepted and `overrun` is not set.
- FIFO read/write pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap modulo `FIFO_DEPTH`. Full and empty are derived from `fifo_count`.

## Timing
- Reset values (asynchronous, immediate on `reset=0`):
  - `txd=1`, `tx_busy=0`, `fifo_full=0`, `fifo_count=0`, `overrun=0`.
  - FSM in IDLE; FIFO pointers and baud counter at 0.
- Reset mid-frame aborts the frame: `txd` goes high immediately and the buffered bytes are discarded.
- Latency with an empty FIFO and the FSM in IDLE:
  - Push at edge N.
  - Pop and START entry at edge N+1; `txd` falls after edge N+1.
- Frame length is 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- `txd` is driven directly from a register, so there are no combinational glitches.
- `fifo_count`, `fifo_full` and `overrun` update on the same edge as the push, pop or clear that changes them.

## Configuration
- `MMIO_UART_TX_PARITY_EN` defined: an even-parity bit (XOR of the 8 data bits) is sent in PARITY, between DATA and STOP, for `CLKS_PER_BIT` cycles.
- `MMIO_UART_TX_PARITY_EN` undefined: the PARITY state and its logic are absent, and the frame is 8N1.

## Structure
- Package `mmio_uart_pkg`:
  - FSM state encoding constants.
  - Default `UART_ADDR`.
  - Control-register offset (4).
  - Control bit index for overrun clear (0).
- Sub-module `mmio_uart_fifo`: byte FIFO with push, pop, count, full and empty, parameterized by `FIFO_DEPTH`. It uses the same asynchronous active-low `reset`.
- Top `mmio_uart_tx` contains the address decode, overrun logic, baud counter, FSM and shift register.

## Test plan
All scenarios use `CLKS_PER_BIT=4` and `FIFO_DEPTH=4`.
- Reset: hold `reset=0` for 3 cycles → `txd=1`, `tx_busy=0`, `fifo_count=0`, `overrun=0`. All remain stable after release with no stores.
- Single frame: store 32'h0000_00A5 to `UART_ADDR` at edge N.
  - From edge N+1, `txd` = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles.
  - `tx_busy` drops 40 cycles after edge N+1.
- Decode: store to `UART_ADDR+8`, and a separate cycle with `memwrite=0` and `dataadr=UART_ADDR` → `fifo_count` stays 0 and `txd` stays 1.
- Overrun: six back-to-back stores of 8'h11..8'h16.
  - `fifo_count` is 4 after the sixth edge, 8'h16 is dropped and `overrun=1`.
  - Bytes 8'h11..8'h15 are sent with no gaps between frames.
  - A store of 1 to `UART_ADDR+4` then clears `overrun`.
- Reset mid-frame: assert `reset=0` during DATA with 2 bytes queued → `txd=1` immediately and `fifo_count=0`. No frame follows release.
- Parity (with `MMIO_UART_TX_PARITY_EN`):
  - 8'hA5 gives parity bit 0, 44-cycle frame.
  - 8'h07 gives parity bit 1.
